// File: rtl/input_frame_buffer.sv
// Input frame buffer: collects FRAME_LEN streamed samples, zero-pads frames cut short by in_last,
// then freezes the frame for the processing engine's read port until the controller releases it.
module input_frame_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  ready_for_processing,
  input  logic                  processing_active,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  frame_padded,
  output logic [7:0]            frame_count
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_FULL = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH:0]   ONE_SLOT  = (ADDR_WIDTH + 1)'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     fill_q, fill_d;
  logic                    in_ready_q, in_ready_d;
  logic                    rfp_q, rfp_d;
  logic                    padded_q, padded_d;
  logic [7:0]              count_q, count_d;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   mem [FRAME_LEN];

  logic                    accept_s;
  logic                    last_slot_s;
  logic                    wr_en_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;
  logic [ADDR_WIDTH-1:0]   wr_ptr_s;

  // The write pointer is the low bits of the fill count; it wraps to 0 exactly when the frame is full.
  assign wr_ptr_s    = fill_q[ADDR_WIDTH-1:0];
  assign accept_s    = in_valid && in_ready_q;
  assign last_slot_s = (wr_ptr_s == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FILL;
      fill_q     <= '0;
      in_ready_q <= 1'b0;
      rfp_q      <= 1'b0;
      padded_q   <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      in_ready_q <= in_ready_d;
      rfp_q      <= rfp_d;
      padded_q   <= padded_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: begin
        if (accept_s && last_slot_s) begin
          state_d = S_FULL;
        end else if (accept_s && in_last) begin
          state_d = S_PAD;
        end else begin
          state_d = S_FILL;
        end
      end
      S_PAD: begin
        if (last_slot_s) begin
          state_d = S_FULL;
        end else begin
          state_d = S_PAD;
        end
      end
      S_FULL: begin
        if (processing_active) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_FULL;
        end
      end
      S_HOLD: begin
        if (!processing_active) begin
          state_d = S_FILL;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Handshake outputs are registered from the next state so they carry no input-to-output path.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_data_s  = in_data;
    fill_d     = fill_q;
    padded_d   = padded_q;
    count_d    = count_q;
    in_ready_d = (state_d == S_FILL);
    rfp_d      = (state_d == S_FULL);
    case (state_q)
      S_FILL: begin
        if (accept_s) begin
          wr_en_s = 1'b1;
          fill_d  = fill_q + ONE_SLOT;
          if (in_last && !last_slot_s) begin
            padded_d = 1'b1;
          end else begin
            padded_d = padded_q;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      S_PAD: begin
        wr_en_s   = 1'b1;
        wr_data_s = '0;
        fill_d    = fill_q + ONE_SLOT;
      end
      S_FULL: begin
        if (processing_active) begin
          count_d = count_q + 8'd1;
        end else begin
          count_d = count_q;
        end
      end
      S_HOLD: begin
        if (!processing_active) begin
          fill_d   = '0;
          padded_d = 1'b0;
        end else begin
          fill_d   = fill_q;
        end
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Sample storage is intentionally not reset; unwritten slots are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_s] <= wr_data_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign in_ready             = in_ready_q;
  assign ready_for_processing = rfp_q;
  assign rd_data              = rd_data_q;
  assign fill_level           = fill_q;
  assign frame_padded         = padded_q;
  assign frame_count          = count_q;

endmodule

// File: tb/tb_input_frame_buffer.sv
// Directed self-checking bench for input_frame_buffer: full frame, handoff and reads, backpressure,
// short padded frame, reset mid-fill, and frame_count wrap.
module tb_input_frame_buffer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        ready_for_processing;
  logic        processing_active;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic [6:0]  fill_level;
  logic        frame_padded;
  logic [7:0]  frame_count;

  int errors = 0;
  int checks = 0;

  input_frame_buffer #(
    .DATA_WIDTH(16),
    .FRAME_LEN (64),
    .ADDR_WIDTH(6)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_last             (in_last),
    .in_ready            (in_ready),
    .ready_for_processing(ready_for_processing),
    .processing_active   (processing_active),
    .rd_en               (rd_en),
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
    .fill_level          (fill_level),
    .frame_padded        (frame_padded),
    .frame_count         (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_samples(input int n, input logic last, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 16'(i);
      in_last  = last && (i == n - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [5:0] addr, input logic [15:0] exp);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    rd_en   = 1'b0;
    check_eq(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset             = 1'b1;
    in_valid          = 1'b0;
    in_data           = 16'd0;
    in_last           = 1'b0;
    processing_active = 1'b0;
    rd_en             = 1'b0;
    rd_addr           = 6'd0;

    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_rfp", 32'(ready_for_processing), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_fill", 32'(fill_level), 32'd0);
    check_eq("rst_padded", 32'(frame_padded), 32'd0);
    check_eq("rst_count", 32'(frame_count), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Full frame 1..64
    send_samples(32, 1'b0, 16'd1);
    check_eq("half_fill", 32'(fill_level), 32'd32);
    check_eq("half_in_ready", 32'(in_ready), 32'd1);
    send_samples(32, 1'b0, 16'd33);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    check_eq("full_rfp", 32'(ready_for_processing), 32'd1);
    check_eq("full_fill", 32'(fill_level), 32'd64);
    check_eq("full_padded", 32'(frame_padded), 32'd0);

    // Backpressure: upstream keeps offering a sample through FULL and HOLD
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    tick();
    tick();
    check_eq("rfp_holds", 32'(ready_for_processing), 32'd1);
    processing_active = 1'b1;
    tick();
    check_eq("hold_rfp", 32'(ready_for_processing), 32'd0);
    check_eq("hold_count", 32'(frame_count), 32'd1);
    check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    check_eq("hold_fill", 32'(fill_level), 32'd64);
    read_check("rd_addr0", 6'd0, 16'd1);
    read_check("rd_addr31", 6'd31, 16'd32);
    read_check("rd_addr63", 6'd63, 16'd64);
    rd_addr = 6'd0;
    tick();
    check_eq("rd_data_holds", 32'(rd_data), 32'd64);
    repeat (5) tick();
    processing_active = 1'b0;
    in_valid          = 1'b0;
    tick();
    check_eq("release_in_ready", 32'(in_ready), 32'd1);
    check_eq("release_fill", 32'(fill_level), 32'd0);
    check_eq("release_rfp", 32'(ready_for_processing), 32'd0);
    read_check("bp_addr63_intact", 6'd63, 16'd64);

    // Short frame: 10 samples, in_last on the 10th, 54 pad cycles
    send_samples(10, 1'b1, 16'd1);
    check_eq("short_in_ready", 32'(in_ready), 32'd0);
    check_eq("short_padded", 32'(frame_padded), 32'd1);
    check_eq("short_fill", 32'(fill_level), 32'd10);
    check_eq("short_rfp_early", 32'(ready_for_processing), 32'd0);
    repeat (53) tick();
    check_eq("pad53_rfp", 32'(ready_for_processing), 32'd0);
    check_eq("pad53_fill", 32'(fill_level), 32'd63);
    tick();
    check_eq("pad_done_rfp", 32'(ready_for_processing), 32'd1);
    check_eq("pad_done_fill", 32'(fill_level), 32'd64);
    check_eq("pad_done_padded", 32'(frame_padded), 32'd1);
    read_check("short_addr9", 6'd9, 16'd10);
    read_check("short_addr10", 6'd10, 16'd0);
    read_check("short_addr63", 6'd63, 16'd0);
    processing_active = 1'b1;
    tick();
    check_eq("short_count", 32'(frame_count), 32'd2);
    processing_active = 1'b0;
    tick();
    check_eq("short_padded_clr", 32'(frame_padded), 32'd0);
    check_eq("short_release_ready", 32'(in_ready), 32'd1);

    // Reset mid-fill
    send_samples(30, 1'b0, 16'd100);
    check_eq("mid_fill", 32'(fill_level), 32'd30);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_fill", 32'(fill_level), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("mid_rst_count", 32'(frame_count), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("mid_post_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_post_fill", 32'(fill_level), 32'd0);

    // Fresh frame with processing_active already high when FULL is entered
    send_samples(63, 1'b0, 16'd200);
    processing_active = 1'b1;
    send_samples(1, 1'b0, 16'd263);
    check_eq("early_pa_rfp", 32'(ready_for_processing), 32'd1);
    check_eq("early_pa_fill", 32'(fill_level), 32'd64);
    tick();
    check_eq("early_pa_rfp_one", 32'(ready_for_processing), 32'd0);
    check_eq("early_pa_count", 32'(frame_count), 32'd1);
    processing_active = 1'b0;
    tick();
    check_eq("early_pa_in_ready", 32'(in_ready), 32'd1);
    read_check("new_addr5", 6'd5, 16'd205);
    read_check("new_addr63", 6'd63, 16'd263);

    // frame_count wrap
    for (int f = 0; f < 254; f++) begin
      send_samples(64, 1'b0, 16'd0);
      processing_active = 1'b1;
      tick();
      processing_active = 1'b0;
      tick();
    end
    check_eq("count_255", 32'(frame_count), 32'd255);
    send_samples(64, 1'b0, 16'd0);
    processing_active = 1'b1;
    tick();
    processing_active = 1'b0;
    tick();
    check_eq("count_wrap", 32'(frame_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_frame_buffer.md
# input_frame_buffer

Upstream input stage of the DSP accelerator: accepts a streaming sample interface, collects FRAME_LEN samples into an on-chip frame buffer, and hands the completed frame to the controller by raising `ready_for_processing`. While the controller runs FIR or FFT (`processing_active` high), the buffer is frozen and serves the engine's read port. It zero-pads short frames terminated by `in_last`.

## Interface
- DATA_WIDTH, 16, sample width in bits
- FRAME_LEN, 64, samples per frame (power of two, ≥4)
- ADDR_WIDTH, 6, log2(FRAME_LEN)

- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-high
- in_valid  input  1  upstream sample valid
- in_data  input  DATA_WIDTH  upstream sample
- in_last  input  1  final sample of a short frame (qualified by in_valid && in_ready)
- in_ready  output  1  buffer accepts a sample this cycle
- ready_for_processing  output  1  frame complete, to controller
- processing_active  input  1  from controller; high while the engine owns the buffer
- rd_en  input  1  engine read strobe
- rd_addr  input  ADDR_WIDTH  engine read address
- rd_data  output  DATA_WIDTH  read data, one cycle after rd_en
- fill_level  output  ADDR_WIDTH+1  samples written in the current frame (0..FRAME_LEN)
- frame_padded  output  1  current/last frame was zero-padded
- frame_count  output  8  frames handed off, wraps 255→0

## Operation
- States: FILL, PAD, FULL, HOLD. Reset → FILL, wr_ptr=0.
- FILL: in_ready=1. On in_valid&&in_ready, write in_data at wr_ptr, wr_ptr++.
  - Accept at wr_ptr=FRAME_LEN-1 (with or without in_last) → FULL.
  - Accept with in_last at wr_ptr<FRAME_LEN-1 → PAD, frame_padded←1.
- PAD: in_ready=0. Write 0 at wr_ptr each cycle, wr_ptr++. The write at FRAME_LEN-1 → FULL.
- FULL: in_ready=0, ready_for_processing=1. On the first cycle with processing_active=1 → HOLD; frame_count++.
- HOLD: in_ready=0, ready_for_processing=0. When processing_active=0 → FILL; wr_ptr←0, frame_padded←0.
- fill_level = number of slots written this frame, including pad writes. It reads FRAME_LEN in FULL and HOLD, and resets to 0 on entry to FILL.
- Read port is independent of state. rd_data is registered, updates only on rd_en, and holds otherwise. Reads during FILL/PAD return current memory contents, which are valid for written slots only.
- Memory array is not reset. Reads of unwritten slots after reset are don't-care.
- Reset mid-operation in any state: state FILL, wr_ptr=0, partial frame discarded, frame_count=0, frame_padded=0.

## Timing
- Reset values: in_ready=0 while reset is high, then 1 in the first cycle after reset. ready_for_processing=0, rd_data=0, fill_level=0, frame_padded=0, frame_count=0.
- in_ready and ready_for_processing are pure decodes of the registered state, with no combinational path from inputs.
- Full-frame latency: FRAME_LEN-th accept at edge N → in_ready=0 and ready_for_processing=1 from edge N.
- Pad latency: in_last accepted at index k → FRAME_LEN-1-k PAD cycles, then ready_for_processing=1.
- ready_for_processing stays high for at least one cycle and holds until processing_active is sampled high. If processing_active is already high on entry to FULL, ready_for_processing is high for exactly one cycle.
- HOLD → FILL transition: one cycle after processing_active is sampled low, in_ready=1.
- Back-to-back input: one sample per cycle sustained in FILL. No sample is ever dropped, because backpressure is through in_ready only.
- Read latency: 1 cycle, rd_en at edge M → rd_data valid after edge M+1.

## Test plan
- Full frame: reset 2 cycles, stream in_data=1..64 with in_valid held → ready_for_processing rises on the cycle after the 64th accept, in_ready=0, fill_level=64, frame_padded=0.
- Handoff: processing_active=1 for 10 cycles, then 0. Read addr 0, 31, 63 during HOLD → 1, 32, 64 one cycle after rd_en. frame_count=1, in_ready=1 one cycle after processing_active falls.
- Short frame: stream 10 samples, in_last on the 10th → 54 PAD cycles, then ready_for_processing=1. Reads at addr 9 and 10 return 10 and 0; frame_padded=1.
- Backpressure: hold in_valid=1 through FULL/HOLD → no writes occur and the frame stays intact. Verify addr 63 is unchanged after HOLD.
- Reset mid-fill: reset after 30 accepts → fill_level=0, in_ready=1 next cycle. A following 64-sample frame completes normally.
- Wrap: run 256 frames → frame_count reads 0.
